// File: rtl/kamikaze_mem_arbiter.sv
// kamikaze_mem_arbiter: shares one 32-bit memory port between instruction
// fetch and the load/store unit. One transaction at a time. Data requests
// win by default. A fetch that has watched STARVE_LIMIT data grants in a row
// wins the next arbitration. Hung transactions are aborted after TIMEOUT
// busy cycles with an error response.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no owner, arbitrating every cycle, mem_req_o low
// S_BUSY_IF | fetch owns the memory port, waiting for mem_ack_i or tmo
// S_BUSY_DM | data owns the memory port, waiting for mem_ack_i or tmo
module kamikaze_mem_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        if_err_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_be_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        dm_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [1:0]  grant_o
);

    // State encoding doubles as the grant_o code.
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_BUSY_IF = 2'b01;
    localparam logic [1:0] S_BUSY_DM = 2'b10;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);
    localparam bit         TMO_EN     = (TIMEOUT != 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic busy, tmo, done, own_if, own_dm;

    // Byte-offset bits are dropped: the memory port is word addressed.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{if_addr_i[1:0], dm_addr_i[1:0]};

    assign busy   = (state_q != S_IDLE);
    assign own_if = (state_q == S_BUSY_IF);
    assign own_dm = (state_q == S_BUSY_DM);
    assign tmo    = TMO_EN && busy && (cnt_q == CNT_LAST);
    assign done   = busy && (mem_ack_i || tmo);

    // Completion strobes and read data, gated by owner; ack beats timeout.
    always_comb begin
        if_ack_o   = own_if && (mem_ack_i || tmo);
        dm_ack_o   = own_dm && (mem_ack_i || tmo);
        if_err_o   = own_if && tmo && !mem_ack_i;
        dm_err_o   = own_dm && tmo && !mem_ack_i;
        if_rdata_o = (own_if && mem_ack_i) ? mem_rdata_i : 32'h0;
        dm_rdata_o = (own_dm && mem_ack_i) ? mem_rdata_i : 32'h0;
    end

    // Arbitration, request capture, starvation streak and timeout counter.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_req_i && (!dm_req_i || streak_q == STREAK_MAX)) begin
                    state_d     = S_BUSY_IF;
                    streak_d    = 4'd0;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = {if_addr_i[31:2], 2'b00};
                    mem_wdata_d = 32'h0;
                end else if (dm_req_i) begin
                    state_d     = S_BUSY_DM;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_be_d    = dm_be_i;
                    mem_addr_d  = {dm_addr_i[31:2], 2'b00};
                    mem_wdata_d = dm_wdata_i;
                    if (!if_req_i) begin
                        streak_d = 4'd0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end
            end
            default: begin
                if (done) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // State and registered memory-side outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            streak_q    <= 4'd0;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign grant_o     = state_q;

endmodule

// File: tb/tb_kamikaze_mem_arbiter.sv
// Bench for kamikaze_mem_arbiter: directed scenarios followed by random
// request/latency traffic, checked against a behavioural arbitration model.
module tb_kamikaze_mem_arbiter;

    localparam int STARVE = 3;
    localparam int TMO    = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_err_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        dm_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [1:0]  grant_o;

    int n_assert = 0;
    int n_fail   = 0;
    // Model: consecutive data grants handed out while a fetch was waiting.
    int dm_wins_while_if_waits = 0;

    always #5 clk_i = ~clk_i;

    kamikaze_mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o), .if_err_o(if_err_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
        .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .grant_o(grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle (1 ns after the edge) with requests already
    // driven. Runs one transaction; memory acks in BUSY cycle lat+1
    // (lat >= TMO means it never acks). Returns 1 ns after the edge that
    // brings the arbiter back to IDLE.
    task automatic txn(input int lat, output logic [1:0] g);
        logic        if_w, ack_in, fin;
        logic [31:0] e_addr, e_wd, rd;
        logic        e_we;
        logic [3:0]  e_be;
        if_w = if_req_i && (!dm_req_i || dm_wins_while_if_waits >= STARVE);
        if (if_w) begin
            dm_wins_while_if_waits = 0;
            e_addr = if_addr_i & 32'hFFFF_FFFC;
            e_we   = 1'b0;
            e_be   = 4'hF;
            e_wd   = 32'h0;
        end else begin
            dm_wins_while_if_waits = if_req_i ? dm_wins_while_if_waits + 1 : 0;
            e_addr = dm_addr_i & 32'hFFFF_FFFC;
            e_we   = dm_we_i;
            e_be   = dm_be_i;
            e_wd   = dm_wdata_i;
        end
        @(posedge clk_i); #1;
        g = grant_o;
        chk("grant", 32'(grant_o), if_w ? 32'd1 : 32'd2);
        fin = 1'b0;
        for (int k = 1; k <= TMO + 1 && !fin; k++) begin
            ack_in      = (k == lat + 1);
            rd          = $urandom;
            mem_ack_i   = ack_in;
            mem_rdata_i = rd;
            #1;
            chk("mem_req", 32'(mem_req_o), 32'd1);
            chk("mem_addr", mem_addr_o, e_addr);
            chk("mem_be", 32'(mem_be_o), 32'(e_be));
            chk("mem_we", 32'(mem_we_o), 32'(e_we));
            if (!if_w) chk("mem_wdata", mem_wdata_o, e_wd);
            fin = ack_in || (k == TMO);
            chk("if_ack", 32'(if_ack_o), 32'(if_w && fin));
            chk("dm_ack", 32'(dm_ack_o), 32'(!if_w && fin));
            chk("if_err", 32'(if_err_o), 32'(if_w && fin && !ack_in));
            chk("dm_err", 32'(dm_err_o), 32'(!if_w && fin && !ack_in));
            chk("if_rdata", if_rdata_o, (if_w && ack_in) ? rd : 32'h0);
            chk("dm_rdata", dm_rdata_o, (!if_w && ack_in) ? rd : 32'h0);
            @(posedge clk_i); #1;
        end
        mem_ack_i = 1'b0;
        chk("txn_done", 32'(fin), 32'd1);
        chk("idle_grant", 32'(grant_o), 32'd0);
        chk("idle_mem_req", 32'(mem_req_o), 32'd0);
    endtask

    task automatic stray_ack();
        mem_ack_i   = 1'b1;
        mem_rdata_i = $urandom;
        #1;
        chk("stray_if_ack", 32'(if_ack_o), 32'd0);
        chk("stray_dm_ack", 32'(dm_ack_o), 32'd0);
        chk("stray_dm_rdata", dm_rdata_o, 32'h0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        chk("stray_grant", 32'(grant_o), 32'd0);
    endtask

    initial begin
        logic [1:0] g;
        rst_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = 32'h0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = 4'h0;
        dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
        mem_rdata_i = 32'h0; mem_ack_i = 1'b0;

        // Reset values, during and right after reset.
        #12;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_be", 32'(mem_be_o), 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_rst_grant", 32'(grant_o), 32'd0);
        chk("post_rst_we", 32'(mem_we_o), 32'd0);

        // Fetch of an unaligned address, ack one cycle after request.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0006;
        txn(1, g);
        if_req_i = 1'b0;

        // Memory ack while idle must not reach either side.
        stray_ack();

        // Both requesting continuously: DM DM DM IF DM DM DM IF.
        if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if_addr_i = $urandom; dm_addr_i = $urandom;
            txn(0, g);
            chk("prio_order", 32'(g), (i % 4 == 3) ? 32'd1 : 32'd2);
        end
        if_req_i = 1'b0;

        // Stalled write: outputs stable for 6 busy cycles, single ack.
        dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_wdata_i = 32'hDEAD_BEEF;
        dm_addr_i = 32'h1000_0013;
        txn(5, g);

        // Memory never acks: abort in the last allowed busy cycle.
        dm_we_i = 1'b0; dm_addr_i = 32'h2000_0040;
        txn(TMO, g);
        // Ack arriving in the timeout cycle completes normally.
        txn(TMO - 1, g);
        dm_req_i = 1'b0;

        // Asynchronous reset in the middle of a transaction.
        dm_req_i = 1'b1; dm_addr_i = 32'h3000_0008;
        @(posedge clk_i); #2;
        chk("pre_rst_mem_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("async_rst_grant", 32'(grant_o), 32'd0);
        chk("async_rst_dm_ack", 32'(dm_ack_o), 32'd0);
        #1;
        rst_i = 1'b0;
        dm_wins_while_if_waits = 0;
        txn(0, g);
        dm_req_i = 1'b0;

        // Random traffic; the losing requester keeps its request held.
        for (int i = 0; i < 80; i++) begin
            if (!if_req_i && $urandom_range(0, 1) == 1) begin
                if_req_i = 1'b1; if_addr_i = $urandom;
            end
            if (!dm_req_i && $urandom_range(0, 1) == 1) begin
                dm_req_i = 1'b1; dm_we_i = 1'($urandom); dm_be_i = 4'($urandom);
                dm_addr_i = $urandom; dm_wdata_i = $urandom;
            end
            if (!if_req_i && !dm_req_i) begin
                stray_ack();
                dm_req_i = 1'b1; dm_we_i = 1'($urandom); dm_be_i = 4'($urandom);
                dm_addr_i = $urandom; dm_wdata_i = $urandom;
            end
            txn($urandom_range(0, TMO), g);
            if (g == 2'b01) if_req_i = 1'b0;
            else if (g == 2'b10) dm_req_i = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/kamikaze_mem_arbiter.md
# kamikaze_mem_arbiter

Two-master, one-slave arbiter that shares a single 32-bit memory port between the instruction fetch unit and the load/store unit. It sits between `kamikaze_fetch` / the LSU and the external memory bus. It sequences one transaction at a time through a small FSM, gives data accesses priority with a bounded anti-starvation rule for fetch, and aborts hung transactions with an error response.

## Interface
- `STARVE_LIMIT`, default 3: max consecutive data grants while a fetch request waits; range 1..15.
- `TIMEOUT`, default 64: cycles in BUSY without `mem_ack_i` before abort; range 1..255; 0 disables the timeout.

Ports:
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `if_req_i` in 1: fetch request, held with `if_addr_i` until `if_ack_o`.
- `if_addr_i` in 32: fetch byte address.
- `if_rdata_o` out 32: fetch read data, valid with `if_ack_o`.
- `if_ack_o` out 1: fetch transaction complete, 1-cycle pulse.
- `if_err_o` out 1: fetch transaction aborted by timeout, qualifies `if_ack_o`.
- `dm_req_i` in 1: data request, held with its qualifiers until `dm_ack_o`.
- `dm_we_i` in 1: data write enable.
- `dm_be_i` in 4: data byte enables.
- `dm_addr_i` in 32: data byte address.
- `dm_wdata_i` in 32: data write data.
- `dm_rdata_o` out 32: data read data, valid with `dm_ack_o`.
- `dm_ack_o` out 1: data transaction complete, 1-cycle pulse.
- `dm_err_o` out 1: data transaction aborted by timeout.
- `mem_req_o` out 1: memory request, held until ack or abort.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out 4: memory byte enables.
- `mem_addr_o` out 32: memory word address, bits [1:0] forced to 00.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: memory read data, valid with `mem_ack_i`.
- `mem_ack_i` in 1: memory completion strobe.
- `grant_o` out 2: current owner. 00 = none, 01 = fetch, 10 = data.

## Operation
- FSM states:
  - IDLE: `mem_req_o` = 0, `grant_o` = 00.
  - BUSY_IF
  - BUSY_DM
- IDLE arbitration, sampled each cycle:
  - Only one request high: grant that requester.
  - Both high: grant data, unless `streak` = `STARVE_LIMIT`, in which case grant fetch.
  - Neither high: stay in IDLE.
- On grant, register the mem_* outputs from the winner:
  - Fetch: `we` = 0, `be` = 1111, `addr` = {`if_addr_i`[31:2], 00}.
  - Data: `dm_we_i`, `dm_be_i`, {`dm_addr_i`[31:2], 00}, `dm_wdata_i`.
- `mem_*` outputs stay constant throughout BUSY.
- `streak`, 4 bits:
  - Increments on each data grant made while `if_req_i` = 1.
  - Clears on a fetch grant.
  - Clears on a data grant made with `if_req_i` = 0.
  - Saturates at `STARVE_LIMIT`.
- Ack and rdata are combinational, gated by owner:
  - `if_ack_o` = BUSY_IF & (`mem_ack_i` | `tmo`). Likewise for `dm_ack_o`.
  - Owner's rdata = `mem_rdata_i` on normal ack, 0 on abort.
  - Non-owner's rdata = 0.
  - err = `tmo` & !`mem_ack_i`.
- BUSY → IDLE on the edge where `mem_ack_i` = 1 or `tmo` = 1. `mem_req_o` falls on that same edge.
- `tmo`:
  - Asserted when `TIMEOUT` != 0 and the cycle counter = `TIMEOUT` − 1.
  - The counter clears on entry to BUSY.
  - If ack and timeout coincide, ack wins: normal completion, err = 0.
- `mem_ack_i` while in IDLE is ignored: no ack to either side, no state change.
- A requester still holding req in the cycle after its ack starts a new transaction. The arbiter re-samples req in IDLE.

## Timing
- Reset, asynchronous: all registered outputs are 0 while `rst_i` = 1 and immediately after deassertion:
  - `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` = 0.
  - `grant_o` = 00, state IDLE, `streak` = 0, timeout counter = 0.
- Combinational outputs are 0 in IDLE.
- Reset mid-BUSY drops `mem_req_o` with no ack to the requester. The slave must tolerate this.
- Cycle T: IDLE with req high. Edge T+1: `mem_req_o` = 1, `grant_o` set.
- Ack in cycle T+1 gives a minimum of 2 cycles per transaction. Back-to-back throughput is 1 transaction per 2 cycles.
- Ack-to-requester latency from `mem_ack_i` is 0 cycles (combinational).
- Timeout with `TIMEOUT` = N: abort ack pulses in the Nth BUSY cycle. IDLE follows on the next edge.

## Test plan
- Fetch only, `if_addr_i` = 0x0000_0006, memory acks 1 cycle after req → `mem_addr_o` = 0x0000_0004, `mem_be_o` = 1111, `if_ack_o` pulses in cycle 2 with `if_rdata_o` = `mem_rdata_i`, then `grant_o` = 00.
- Simultaneous `if_req_i` and `dm_req_i` held high, `STARVE_LIMIT` = 3, immediate acks → grant order DM, DM, DM, IF, DM…; `streak` clears after the IF grant.
- Data write `dm_be_i` = 0011, `dm_wdata_i` = 0xDEADBEEF, memory stalls 5 cycles → `mem_*` stable for all 6 BUSY cycles; `dm_ack_o` pulses only once; `if_ack_o` stays 0.
- `TIMEOUT` = 4, memory never acks → `dm_ack_o` = `dm_err_o` = 1 in the 4th BUSY cycle, `dm_rdata_o` = 0, `mem_req_o` = 0 on the next edge.
- Ack arriving in the exact timeout cycle → `err` = 0, data passed through. Stray `mem_ack_i` in IDLE → no ack out.
- `rst_i` pulsed asynchronously mid-BUSY → `mem_req_o` and `grant_o` drop to 0 before the next clock edge; a new request after reset is granted normally.
